// File: rtl/gray_counter.sv
// ============================================================================
// Module   : gray_counter
// Brief    : W-bit Gray-code counter with valid/ready handshake, load and
//            terminal-count pulse. Define GRAY_UPDOWN_EN to honour dir.
// Revision : 1.0
// ============================================================================
`default_nettype none

module gray_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         dir,
  input  logic         ready,
  output logic [W-1:0] g,
  output logic         valid,
  output logic         tc
);

  localparam logic [0:0]   IDLE = 1'b0;
  localparam logic [0:0]   RUN  = 1'b1;
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] TOP  = {1'b1, {(W-1){1'b0}}};

  if (W < 2 || W > 8) begin : g_bad_width
    $error("gray_counter: W must be in 2..8");
  end

  logic [0:0]   state;
  logic [W-1:0] bin;
  logic [W-1:0] bin_next;
  logic [W-1:0] g_next;
  logic         wrap;
  logic         xfer;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    logic acc;
    acc = 1'b0;
    bin = '0;
    for (int i = W - 1; i >= 0; i--) begin
      acc    = acc ^ g[i];
      bin[i] = acc;
    end
  end

`ifdef GRAY_UPDOWN_EN
  assign bin_next = dir ? (bin + ONE) : (bin - ONE);
  assign wrap     = dir ? (g == TOP) : (g == '0);
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign bin_next   = bin + ONE;
  assign wrap       = (g == TOP);
`endif

  assign g_next = bin_next ^ (bin_next >> 1);
  assign valid  = (state == RUN);
  assign xfer   = valid && ready && en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g     <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      // Load overrides a same-cycle transfer; the presented value is consumed.
      state <= RUN;
      g     <= din;
      tc    <= 1'b0;
    end else if (!en) begin
      state <= IDLE;
      tc    <= 1'b0;
    end else begin
      state <= RUN;
      if (xfer) begin
        g  <= g_next;
        tc <= wrap;
      end else begin
        tc <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gray_counter.sv
// ============================================================================
// Module   : tb_gray_counter
// Brief    : Scoreboard bench for gray_counter (W=4) using directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gray_counter;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] g;
    logic         v;
    logic         tc;
    logic         step;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         dir = 1'b1;
  logic         ready = 1'b0;
  logic [W-1:0] g;
  logic         valid;
  logic         tc;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  logic [W-1:0] last_exp_g = '0;

  logic [W-1:0] up_seq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};

  gray_counter #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (load),
    .din   (din),
    .dir   (dir),
    .ready (ready),
    .g     (g),
    .valid (valid),
    .tc    (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector on the falling edge and queue its expected post-edge state.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [W-1:0] d, input logic dr, input logic rd,
                      input logic [W-1:0] eg, input logic ev, input logic etc);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; load = l; din = d; dir = dr; ready = rd;
    x.g    = eg;
    x.v    = ev;
    x.tc   = etc;
    x.step = !r && !l && (eg != last_exp_g);
    last_exp_g = eg;
    q.push_back(x);
  endtask

  // Monitor: compare the DUT against the scoreboard just after each edge.
  initial begin : monitor
    logic [W-1:0] prev_g;
    exp_t x;
    prev_g = '0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("g", int'(g), int'(x.g));
        check("valid", int'(valid), int'(x.v));
        check("tc", int'(tc), int'(x.tc));
        if (x.step)
          check("one_bit_change", $countones(g ^ prev_g), 1);
        prev_g = g;
      end
    end
  end

  initial begin : stimulus
    // Reset state
    step(1, 0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
    step(1, 1, 0, 4'h0, 1, 1, 4'h0, 0, 0);
    // IDLE -> RUN with g unchanged, then a full up cycle with wrap pulse
    step(0, 1, 0, 4'h0, 1, 1, 4'h0, 1, 0);
    for (int k = 1; k <= 16; k++)
      step(0, 1, 0, 4'h0, 1, 1, up_seq[k % 16], 1, (k == 16));
    // Advance to 0110, then stall with ready low
    for (int k = 1; k <= 4; k++)
      step(0, 1, 0, 4'h0, 1, 1, up_seq[k], 1, 0);
    for (int k = 0; k < 5; k++)
      step(0, 1, 0, 4'h0, 1, 0, 4'b0110, 1, 0);
    step(0, 1, 0, 4'h0, 1, 1, 4'b0111, 1, 0);
    // Load 0011 during a transfer, then drop and restore en
    step(0, 1, 1, 4'b0011, 1, 1, 4'b0011, 1, 0);
    step(0, 0, 0, 4'h0, 1, 1, 4'b0011, 0, 0);
    step(0, 0, 0, 4'h0, 1, 1, 4'b0011, 0, 0);
    step(0, 1, 0, 4'h0, 1, 1, 4'b0011, 1, 0);
    step(0, 1, 0, 4'h0, 1, 1, 4'b0010, 1, 0);
    // Load 1101 during a transfer: no increment applied
    step(0, 1, 1, 4'b1101, 1, 1, 4'b1101, 1, 0);
    step(0, 1, 0, 4'h0, 1, 1, 4'b1111, 1, 0);
    step(0, 1, 0, 4'h0, 1, 1, 4'b1110, 1, 0);
    // Load from IDLE with en low, then wrap from 1000
    step(0, 0, 0, 4'h0, 1, 1, 4'b1110, 0, 0);
    step(0, 0, 1, 4'b1000, 1, 1, 4'b1000, 1, 0);
    step(0, 1, 0, 4'h0, 1, 1, 4'b0000, 1, 1);
    step(0, 1, 0, 4'h0, 1, 1, 4'b0001, 1, 0);
`ifdef GRAY_UPDOWN_EN
    // Down count: wrap from 0000 to 1000, then direction changes
    step(0, 1, 1, 4'b0000, 1, 1, 4'b0000, 1, 0);
    step(0, 1, 0, 4'h0, 0, 1, 4'b1000, 1, 1);
    step(0, 1, 0, 4'h0, 0, 1, 4'b1001, 1, 0);
    step(0, 1, 0, 4'h0, 0, 1, 4'b1011, 1, 0);
    step(0, 1, 0, 4'h0, 1, 1, 4'b1001, 1, 0);
`else
    // dir is ignored: dir=0 still counts up
    step(0, 1, 0, 4'h0, 0, 1, 4'b0011, 1, 0);
    step(0, 1, 0, 4'h0, 0, 1, 4'b0010, 1, 0);
`endif
    // Reset mid-count overrides load and en, then restart from 0
    step(1, 1, 1, 4'b1111, 1, 1, 4'b0000, 0, 0);
    step(0, 1, 0, 4'h0, 1, 1, 4'b0000, 1, 0);
    step(0, 1, 0, 4'h0, 1, 1, 4'b0001, 1, 0);
    step(0, 1, 0, 4'h0, 1, 1, 4'b0011, 1, 0);

    @(posedge clk);
    #3;
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
